// File: rtl/imm_ext_pkg.sv
// Shared encodings for the immediate-extension pipeline: extension modes and
// skid-buffer occupancy states.
package imm_ext_pkg;

  typedef enum logic [2:0] {
    MODE_ZERO   = 3'd0,
    MODE_SIGN   = 3'd1,
    MODE_UPPER  = 3'd2,
    MODE_BRANCH = 3'd3,
    MODE_SHAMT  = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender. Modes 5-7 are reserved: they produce the
// zero-extended value and raise illegal.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [2:0]       mode,
  output logic [OUT_W-1:0] data,
  output logic             illegal
);

  logic signed [OUT_W-1:0] sext;

  always_comb begin
    sext    = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    data    = '0;
    illegal = 1'b0;
    case (mode)
      MODE_ZERO:   data = OUT_W'(imm);
      MODE_SIGN:   data = sext;
      MODE_UPPER:  data = {imm, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: data = sext <<< 2;
      MODE_SHAMT:  data = OUT_W'(imm[4:0]);
      default: begin
        data    = OUT_W'(imm);
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender followed by a 2-entry skid buffer with a registered in_ready.
// Optional statistics counters are enabled by defining IMM_EXT_STATS_EN.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_illegal
`ifdef IMM_EXT_STATS_EN
  ,
  output logic [15:0]      xfer_count,
  output logic [15:0]      stall_count
`endif
);

  logic [OUT_W-1:0] ext_data_p0;
  logic             ext_ill_p0;
  logic [OUT_W-1:0] out_data_p1, skid_data_p1;
  logic             out_ill_p1, skid_ill_p1;
  logic             ready_q;
  state_e           state_q, state_d;
  logic             in_xfer, out_xfer;
  logic             load_out, load_skid, move_skid;

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm     (in_imm),
    .mode    (in_mode),
    .data    (ext_data_p0),
    .illegal (ext_ill_p0)
  );

  assign in_xfer     = in_valid && ready_q;
  assign out_xfer    = out_valid && out_ready;
  assign in_ready    = ready_q;
  assign out_data    = out_data_p1;
  assign out_illegal = out_ill_p1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_TWO);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (in_xfer) state_d = ST_ONE;
      ST_ONE: begin
        if (in_xfer && !out_xfer)      state_d = ST_TWO;
        else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
      end
      ST_TWO:   if (out_xfer) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Load steering: the output register takes new data whenever it empties
  // this cycle; the skid register only catches an input blocked by a stall.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    load_out  = in_xfer && ((state_q == ST_EMPTY) || (state_q == ST_ONE && out_xfer));
    load_skid = in_xfer && (state_q == ST_ONE) && !out_xfer;
    move_skid = (state_q == ST_TWO) && out_xfer;
  end

  // Stage p1: output register (cleared by reset) and skid register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_data_p1 <= '0;
      out_ill_p1  <= 1'b0;
    end else if (move_skid) begin
      out_data_p1 <= skid_data_p1;
      out_ill_p1  <= skid_ill_p1;
    end else if (load_out) begin
      out_data_p1 <= ext_data_p0;
      out_ill_p1  <= ext_ill_p0;
    end
  end

  always_ff @(posedge Clk) begin
    if (load_skid) begin
      skid_data_p1 <= ext_data_p0;
      skid_ill_p1  <= ext_ill_p0;
    end
  end

`ifdef IMM_EXT_STATS_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      xfer_count  <= '0;
      stall_count <= '0;
    end else begin
      if (out_xfer && xfer_count != 16'hFFFF)
        xfer_count <= xfer_count + 16'd1;
      if (out_valid && !out_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed cases plus randomized traffic checked
// against a queue-based reference of the extension rules.
module tb_imm_extend_pipe;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_imm = '0;
  logic [2:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_illegal;
`ifdef IMM_EXT_STATS_EN
  logic [15:0] xfer_count, stall_count;
`endif

  int vectors = 0;
  int miscompares = 0;
  int xfers = 0;
  int stalls = 0;
  logic [32:0] q[$];

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_imm      (in_imm),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_illegal (out_illegal)
`ifdef IMM_EXT_STATS_EN
    ,
    .xfer_count  (xfer_count),
    .stall_count (stall_count)
`endif
  );

  always #5 Clk = ~Clk;

  // Reference: {illegal, data} from the mode rules using plain integer arithmetic
  function automatic logic [32:0] ref_ext(input logic [15:0] imm, input logic [2:0] mode);
    longint     u, v, r;
    logic [63:0] bits;
    u = longint'(imm);
    v = (u >= 32768) ? u - 65536 : u;
    case (mode)
      3'd0:    r = u;
      3'd1:    r = v;
      3'd2:    r = u * 65536;
      3'd3:    r = v * 4;
      3'd4:    r = u % 32;
      default: r = u;
    endcase
    bits = r;
    return {mode > 3'd4, bits[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check against the model mid-cycle, update the model, cross the edge
  task automatic step(input logic v, input logic [15:0] imm, input logic [2:0] mode,
                      input logic ordy);
    logic do_in, do_out;
    in_valid = v; in_imm = imm; in_mode = mode; out_ready = ordy;
    @(negedge Clk);
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_data", out_data, q[0][31:0]);
      chk("out_illegal", out_illegal, q[0][32]);
    end
    do_out = (q.size() != 0) && ordy;
    do_in  = v && (q.size() < 2);
    if (q.size() != 0 && !ordy) stalls++;
    if (do_out) begin
      void'(q.pop_front());
      xfers++;
    end
    if (do_in) q.push_back(ref_ext(imm, mode));
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_illegal", out_illegal, 0);
`ifdef IMM_EXT_STATS_EN
    chk("rst_xfer_count", xfer_count, 0);
    chk("rst_stall_count", stall_count, 0);
`endif
    q.delete();
    xfers = 0;
    stalls = 0;
    in_valid = 1'b0;
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    #1;
    chk("rst_release_ready_low", in_ready, 0);
    @(posedge Clk); #1;
    chk("first_edge_ready", in_ready, 1);
  endtask

  initial begin
    #1;
    do_reset();

    step(1'b1, 16'h8000, 3'd1, 1'b1);
    chk("sign_latency_valid", out_valid, 1);
    chk("sign_8000", out_data, 32'hFFFF8000);
    step(1'b1, 16'h8000, 3'd0, 1'b1);
    chk("zero_8000", out_data, 32'h00008000);
    step(1'b1, 16'h1234, 3'd2, 1'b1);
    chk("upper_1234", out_data, 32'h12340000);
    step(1'b1, 16'hFFFF, 3'd3, 1'b1);
    chk("branch_ffff", out_data, 32'hFFFFFFFC);
    step(1'b1, 16'hFFFF, 3'd4, 1'b1);
    chk("shamt_ffff", out_data, 32'h0000001F);
    step(1'b1, 16'h00AB, 3'd6, 1'b1);
    chk("mode6_data", out_data, 32'h000000AB);
    chk("mode6_illegal", out_illegal, 1);
    step(1'b0, 16'h0000, 3'd0, 1'b1);

    // Backpressure: two accepted, third held off until the buffer drains
    step(1'b1, 16'h0011, 3'd0, 1'b0);
    step(1'b1, 16'h8022, 3'd1, 1'b0);
    chk("bp_ready_low", in_ready, 0);
    step(1'b1, 16'h0033, 3'd2, 1'b0);
    chk("bp_held_data", out_data, 32'h00000011);
    step(1'b1, 16'h0033, 3'd2, 1'b1);
    chk("bp_second_out", out_data, 32'hFFFF8022);
    step(1'b1, 16'h0033, 3'd2, 1'b1);
    chk("bp_third_out", out_data, 32'h00330000);
    step(1'b0, 16'h0000, 3'd0, 1'b1);
    chk("bp_drained", out_valid, 0);

    // Reset while two entries are buffered
    step(1'b1, 16'h0055, 3'd0, 1'b0);
    step(1'b1, 16'h0066, 3'd0, 1'b0);
    chk("two_full_ready", in_ready, 0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0000, 3'd0, 1'b1);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 16'($urandom), 3'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0);
`ifdef IMM_EXT_STATS_EN
    chk("rand_xfer_count", xfer_count, xfers);
    chk("rand_stall_count", stall_count, stalls);
`endif

    // Five output transfers and three stall cycles
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 16'(i), 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 3'd0, 1'b0);
    step(1'b0, 16'h0000, 3'd0, 1'b1);
`ifdef IMM_EXT_STATS_EN
    chk("stats_xfer_5", xfer_count, 5);
    chk("stats_stall_3", stall_count, 3);
`endif
    chk("stats_model_xfers", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
